// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - DLX fetch program counter with debug run-control FSM
// Optional BRANCH_DELAY_SLOT_EN: flush tied low so the delay-slot instruction executes.
module fetch_pc_unit #(
   parameter int                  PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                PC_sel,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                jump_sel,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                stall,
   input  logic                halt_instr,
   input  logic                run_req,
   input  logic                step_req,
   input  logic                halt_req,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus4,
   output logic                fetch_en,
   output logic                flush,
   output logic [1:0]          run_state,
   output logic                step_done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                advance;
   logic                pc_load;
   logic [PC_WIDTH-1:0] pc_next;

   assign advance  = ((state_q == RUN) || (state_q == STEP)) && !stall;
   // A halt opcode in RUN freezes the pc on the same edge the FSM leaves RUN.
   assign pc_load  = advance && !((state_q == RUN) && halt_instr);
   assign fetch_en = advance;
   assign pc_plus4 = pc + {{(PC_WIDTH-3){1'b0}}, 3'd4};

`ifdef BRANCH_DELAY_SLOT_EN
   assign flush = 1'b0;
`else
   assign flush = advance && (PC_sel || jump_sel);
`endif

   always_comb begin
      pc_next = pc_plus4;
      if (jump_sel) begin
         pc_next = {jump_target[PC_WIDTH-1:2], 2'b00};
      end else if (PC_sel) begin
         pc_next = {branch_target[PC_WIDTH-1:2], 2'b00};
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (step_req) begin
               state_d = STEP;
            end else if (run_req) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (halt_req || halt_instr) begin
               state_d = HALTED;
            end
         end
         STEP: state_d = IDLE;
         HALTED: begin
            if (step_req) begin
               state_d = STEP;
            end else if (run_req) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pc        <= RESET_PC;
         step_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_done <= (state_q == STEP);
         if (pc_load) begin
            pc <= pc_next;
         end
      end
   end

   assign run_state = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

   logic        clock;
   logic        reset_n;
   logic        PC_sel;
   logic [31:0] branch_target;
   logic        jump_sel;
   logic [31:0] jump_target;
   logic        stall;
   logic        halt_instr;
   logic        run_req;
   logic        step_req;
   logic        halt_req;

   logic [31:0] pc_a, pc_plus4_a, pc_b, pc_plus4_b;
   logic        fetch_en_a, flush_a, step_done_a;
   logic        fetch_en_b, flush_b, step_done_b;
   logic [1:0]  run_state_a, run_state_b;

   int tests_run = 0;
   int tests_failed = 0;

   fetch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
      .clock(clock), .reset_n(reset_n), .PC_sel(PC_sel), .branch_target(branch_target),
      .jump_sel(jump_sel), .jump_target(jump_target), .stall(stall), .halt_instr(halt_instr),
      .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .pc(pc_a), .pc_plus4(pc_plus4_a), .fetch_en(fetch_en_a), .flush(flush_a),
      .run_state(run_state_a), .step_done(step_done_a)
   );

   fetch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_b (
      .clock(clock), .reset_n(reset_n), .PC_sel(PC_sel), .branch_target(branch_target),
      .jump_sel(jump_sel), .jump_target(jump_target), .stall(stall), .halt_instr(halt_instr),
      .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .pc(pc_b), .pc_plus4(pc_plus4_b), .fetch_en(fetch_en_b), .flush(flush_b),
      .run_state(run_state_b), .step_done(step_done_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

`ifdef BRANCH_DELAY_SLOT_EN
   localparam logic EXP_FLUSH = 1'b0;
`else
   localparam logic EXP_FLUSH = 1'b1;
`endif

   initial begin
      reset_n = 1'b0; PC_sel = 1'b0; branch_target = '0; jump_sel = 1'b0; jump_target = '0;
      stall = 1'b0; halt_instr = 1'b0; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
      tick(); tick();
      reset_n = 1'b1;
      #1;
      check("rst_pc", pc_a, 32'h0);
      check("rst_pc_plus4", pc_plus4_a, 32'h4);
      check("rst_fetch_en", {31'b0, fetch_en_a}, 32'h0);
      check("rst_flush", {31'b0, flush_a}, 32'h0);
      check("rst_state", {30'b0, run_state_a}, 32'h0);
      check("rst_step_done", {31'b0, step_done_a}, 32'h0);
      check("rst_pc_b", pc_b, 32'hFFFF_FFF8);

      // free run from reset
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      #1;
      check("run_state", {30'b0, run_state_a}, 32'h1);
      check("run_fetch_en", {31'b0, fetch_en_a}, 32'h1);
      check("run_pc0", pc_a, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("run_pc", pc_a, 32'(4 * i));
         if (i == 1) check("wrap_pc_b1", pc_b, 32'hFFFF_FFFC);
         if (i == 2) check("wrap_pc_b2", pc_b, 32'h0000_0000);
      end
      for (int i = 0; i < 4; i++) tick();
      check("run_pc_20", pc_a, 32'h20);

      // taken branch with unaligned target
      PC_sel = 1'b1; branch_target = 32'h0000_0103;
      #1;
      check("br_flush", {31'b0, flush_a}, {31'b0, EXP_FLUSH});
      tick();
      PC_sel = 1'b0;
      check("br_pc", pc_a, 32'h100);

      // jump outranks branch; stall outranks both
      PC_sel = 1'b1; branch_target = 32'h100; jump_sel = 1'b1; jump_target = 32'h200; stall = 1'b1;
      #1;
      check("stall_fetch_en", {31'b0, fetch_en_a}, 32'h0);
      check("stall_flush", {31'b0, flush_a}, 32'h0);
      tick();
      check("stall_pc", pc_a, 32'h100);
      stall = 1'b0;
      #1;
      check("jmp_flush", {31'b0, flush_a}, {31'b0, EXP_FLUSH});
      tick();
      check("jmp_pc", pc_a, 32'h200);
      PC_sel = 1'b0;

      // halt opcode at 0x40
      jump_target = 32'h40;
      tick();
      jump_sel = 1'b0;
      check("jmp40_pc", pc_a, 32'h40);
      halt_instr = 1'b1;
      tick();
      halt_instr = 1'b0;
      check("halt_state", {30'b0, run_state_a}, 32'h3);
      check("halt_pc", pc_a, 32'h40);
      tick();
      check("halted_pc", pc_a, 32'h40);
      check("halted_fetch_en", {31'b0, fetch_en_a}, 32'h0);
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      check("resume_state", {30'b0, run_state_a}, 32'h1);
      check("resume_pc", pc_a, 32'h40);
      tick();
      check("resume_pc44", pc_a, 32'h44);

      // halt_req, then step wins over run in HALTED
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("hreq_state", {30'b0, run_state_a}, 32'h3);
      check("hreq_pc", pc_a, 32'h48);
      step_req = 1'b1; run_req = 1'b1;
      tick();
      step_req = 1'b0; run_req = 1'b0;
      check("hstep_state", {30'b0, run_state_a}, 32'h2);
      tick();
      check("hstep_pc", pc_a, 32'h4C);
      check("hstep_done", {31'b0, step_done_a}, 32'h1);
      check("hstep_idle", {30'b0, run_state_a}, 32'h0);

      // single steps from reset
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("rst2_pc", pc_a, 32'h0);
      for (int i = 1; i <= 3; i++) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         #1;
         check("step_state", {30'b0, run_state_a}, 32'h2);
         check("step_fetch_en", {31'b0, fetch_en_a}, 32'h1);
         tick();
         check("step_pc", pc_a, 32'(4 * i));
         check("step_done", {31'b0, step_done_a}, 32'h1);
         check("step_idle", {30'b0, run_state_a}, 32'h0);
         tick();
         check("step_done_clr", {31'b0, step_done_a}, 32'h0);
      end
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      stall = 1'b1;
      #1;
      check("sstep_fetch_en", {31'b0, fetch_en_a}, 32'h0);
      tick();
      stall = 1'b0;
      check("sstep_pc", pc_a, 32'hC);
      check("sstep_done", {31'b0, step_done_a}, 32'h1);
      check("sstep_idle", {30'b0, run_state_a}, 32'h0);

      // reset mid-run while a redirect is presented
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      tick();
      PC_sel = 1'b1; branch_target = 32'h500;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1; PC_sel = 1'b0;
      #1;
      check("mrst_pc_b", pc_b, 32'hFFFF_FFF8);
      check("mrst_state_b", {30'b0, run_state_b}, 32'h0);
      check("mrst_pc_a", pc_a, 32'h0);
      check("mrst_flush", {31'b0, flush_a}, 32'h0);
      check("mrst_step_done", {31'b0, step_done_a}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch program counter for the DLX pipeline: the consumer of the branch decision produced in instruction decode. It holds the PC, advances it by 4 each fetch, redirects to a branch or jump target on PC_sel / jump_sel, holds on hazard stalls, and drives the IF/ID flush for taken redirects. A small run-control state machine lets the UART debug controller start, single-step and halt the core.

## Interface
- PC_WIDTH, 32, width of pc and target buses
- RESET_PC, 32'h0000_0000, pc value after reset; bits [1:0] must be 0
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- PC_sel  in  1  taken conditional branch, from decode branch logic
- branch_target  in  PC_WIDTH  branch destination, from decode
- jump_sel  in  1  unconditional jump/jr in decode
- jump_target  in  PC_WIDTH  jump destination
- stall  in  1  hazard unit: freeze fetch this cycle
- halt_instr  in  1  halt opcode decoded in ID
- run_req  in  1  UART debug: free-run (level, sampled per cycle)
- step_req  in  1  UART debug: one-cycle pulse, execute one fetch
- halt_req  in  1  UART debug: stop fetching
- pc  out  PC_WIDTH  current fetch address to instruction memory
- pc_plus4  out  PC_WIDTH  pc + 4, for link register writeback
- fetch_en  out  1  instruction memory read enable / IF/ID write enable
- flush  out  1  clear IF/ID register on this edge
- run_state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALTED
- step_done  out  1  one-cycle pulse after a step completes

## Operation
- States: IDLE, RUN, STEP, HALTED. Reset -> IDLE.
- IDLE: step_req -> STEP; else run_req -> RUN.
- RUN: halt_req or halt_instr -> HALTED; else stay.
- STEP: always -> IDLE next cycle; step_done = 1 in the cycle following STEP.
- HALTED: run_req -> RUN; step_req -> STEP (step_req wins over run_req); pc held.
- advance = (run_state is RUN or STEP) & ~stall. fetch_en = advance.
- On advance, next pc: jump_sel ? jump_target : PC_sel ? branch_target : pc + 4. jump_sel outranks PC_sel.
- Targets have bits [1:0] forced to 00 when loaded.
- pc + 4 wraps modulo 2^PC_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), no error.
- Stall wins over redirect: PC_sel/jump_sel with stall=1 are ignored; decode re-presents them.
- halt_instr in RUN: pc does not advance on that edge; state -> HALTED.
- flush = advance & (PC_sel | jump_sel) (subject to Configuration).
- reset_n low in any state, mid-step or mid-redirect: next edge pc = RESET_PC, state IDLE, all pulses 0.

## Timing
- Reset values: pc = RESET_PC, pc_plus4 = RESET_PC + 4, fetch_en = 0, flush = 0, run_state = 0, step_done = 0.
- pc and run_state registered; pc_plus4 combinational from pc.
- fetch_en and flush combinational from run_state, stall, PC_sel, jump_sel; valid same cycle, consumed on the next edge.
- Redirect latency: target appears on pc one edge after PC_sel sampled with advance = 1.
- Step: step_req edge -> STEP (1 cycle, fetch_en = 1 unless stalled) -> IDLE with step_done = 1. A stalled step still returns to IDLE; step_done still pulses, pc unchanged.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: flush is tied to 0; the instruction after a branch/jump (delay slot) executes.
- Undefined: flush asserted per Operation; the fetched wrong-path instruction is squashed.

## Test plan
- Reset, run_req = 1, no redirects for 4 cycles -> pc 0, 4, 8, 12, 16; fetch_en = 1 from cycle after RUN entry.
- RUN at pc 0x20, PC_sel = 1, branch_target 0x100 -> flush = 1 that cycle, next pc = 0x100 (flush 0 with BRANCH_DELAY_SLOT_EN).
- PC_sel = 1 and jump_sel = 1 together, targets 0x100 / 0x200 -> pc = 0x200; same with stall = 1 -> pc holds, flush = 0, fetch_en = 0.
- From IDLE pulse step_req three times -> pc 0, 4, 8, 12; step_done pulses once per step; run_state returns to 0.
- RUN, halt_instr at pc 0x40 -> pc stays 0x40, run_state = 3; run_req -> RUN resumes at 0x44 after one fetch.
- RESET_PC = 32'hFFFF_FFF8, run 3 cycles -> pc FFFF_FFF8, FFFF_FFFC, 0000_0000; reset_n low mid-run -> pc FFFF_FFF8, IDLE.
